spi_flash_reader: RTL and testbench

- Parametrised SPI (mode 0) serial-flash burst reader; successor to the single-byte flash read engine.
- Issues READ (0x03) or FAST_READ (0x0B) with a 24-bit address, then streams 1..2^LEN_W bytes out through a valid/ready port with backpressure.
- Sits between the SoC boot loader / XIP fetch logic and the configuration flash pins (DCLK, nCS, ASDO, DATA0).

---
 rtl/spi_flash_pkg.sv | 17 +
 rtl/spi_sclk_gen.sv | 40 ++++
 rtl/spi_flash_reader.sv | 156 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash burst reader: FSM states and flash opcodes.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_CSH
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         DUMMY_CYC     = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: toggles sclk every CLK_DIV cycles while run is high,
// and flags the clk edge on which sclk will rise or fall.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             toggle;

  assign toggle   = run && (cnt == LAST);
  assign rise_stb = toggle && !sclk;
  assign fall_stb = toggle && sclk;

  // Stopping clears the divider so a restart always waits a full half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (toggle) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI serial-flash burst reader (READ / FAST_READ) with a valid/ready byte stream.
// Define SPI_FLASH_FAST_READ_EN to issue 0x0B followed by 8 dummy clocks.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int ADDR_W      = 24,
  parameter int LEN_W       = 8,
  parameter int CS_HIGH_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              flash_sclk,
  output logic              flash_cs_n,
  output logic              flash_mosi,
  input  logic              flash_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = CMD_FAST_READ;
`else
  localparam logic [7:0] CMD_BYTE = CMD_READ;
`endif

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int CW         = (LEN_W > 8) ? LEN_W : 8;
  localparam int SHW        = 8 + ADDR_W;
  localparam int HW         = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

  state_t          state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   byte_cnt;
  logic [LEN_W-1:0] len_q;
  logic [SHW-1:0]  tx_shift;
  logic [7:0]      rx_shift;
  logic [HW-1:0]   csh_cnt;
  logic            load_pend, draining;
  logic            accept, byte_end, hold, sclk_run, rise_stb, fall_stb;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign byte_end  = rise_stb && (bit_cnt == 3'd7);

  // A data byte may only start clocking once the previous one has been taken.
  assign hold     = (state == ST_DATA) && (bit_cnt == 3'd0) && !flash_sclk && !draining &&
                    rd_valid && !rd_ready;
  assign sclk_run = (state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA}) && !hold;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (sclk_run),
    .sclk     (flash_sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_CMD;
      ST_CMD:   if (byte_end) state_nxt = ST_ADDR;
      ST_ADDR:  if (byte_end && byte_cnt == '0) begin
`ifdef SPI_FLASH_FAST_READ_EN
        state_nxt = ST_DUMMY;
`else
        state_nxt = ST_DATA;
`endif
      end
      ST_DUMMY: if (rise_stb && bit_cnt == 3'(DUMMY_CYC - 1)) state_nxt = ST_DATA;
      ST_DATA:  if (draining && fall_stb) state_nxt = ST_CSH;
      ST_CSH:   if (csh_cnt == HW'(CS_HIGH_CYC - 1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: serialiser, deserialiser, byte/bit counters and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cs_n <= 1'b1;
      flash_mosi <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      len_q      <= '0;
      tx_shift   <= '0;
      rx_shift   <= 8'h00;
      csh_cnt    <= '0;
      load_pend  <= 1'b0;
      draining   <= 1'b0;
    end else begin
      load_pend <= 1'b0;
      if (accept) begin
        flash_cs_n <= 1'b0;
        flash_mosi <= CMD_BYTE[7];
        tx_shift   <= {CMD_BYTE, req_addr} << 1;
        len_q      <= req_len;
        bit_cnt    <= 3'd0;
        byte_cnt   <= '0;
        draining   <= 1'b0;
      end
      if (state == ST_CSH) begin
        flash_cs_n <= 1'b1;
        csh_cnt    <= csh_cnt + HW'(1);
      end else begin
        csh_cnt <= '0;
      end
      if (fall_stb) begin
        if (state == ST_CMD || state == ST_ADDR) begin
          flash_mosi <= tx_shift[SHW-1];
          tx_shift   <= tx_shift << 1;
        end else begin
          flash_mosi <= 1'b0;
        end
      end
      if (rise_stb) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (state == ST_DATA) rx_shift <= {rx_shift[6:0], flash_miso};
        if (bit_cnt == 3'd7) begin
          case (state)
            ST_CMD:  byte_cnt <= CW'(ADDR_BYTES - 1);
            ST_ADDR: byte_cnt <= (byte_cnt == '0) ? CW'(len_q) : byte_cnt - CW'(1);
            ST_DATA: begin
              load_pend <= 1'b1;
              if (byte_cnt == '0) draining <= 1'b1;
              else                byte_cnt <= byte_cnt - CW'(1);
            end
            default: ;
          endcase
        end
      end
      if (load_pend) begin
        rd_data  <= rx_shift;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: behavioural SPI flash model plus
// byte-level expectations derived from a flash content function.
module tb_spi_flash_reader;

  localparam int CLK_DIV     = 2;
  localparam int ADDR_W      = 24;
  localparam int LEN_W       = 8;
  localparam int CS_HIGH_CYC = 4;
  localparam int CLK_T       = 10;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_EXP = 8'h0B;
  localparam int         HDR     = 40;
`else
  localparam logic [7:0] CMD_EXP = 8'h03;
  localparam int         HDR     = 32;
`endif

  logic              clk, rst_n, req_valid, req_ready, rd_valid, rd_ready, busy;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [7:0]        rd_data;
  logic              flash_sclk, flash_cs_n, flash_mosi, flash_miso;

  int checks = 0;
  int errors = 0;

  int          rise_cnt = 0;
  int          cs_falls = 0;
  int          mosi_bad = 0;
  logic [31:0] hdr = '0;
  time         t_r1 = 0, t_r2 = 0, t_cs_rise = 0, cs_gap = 0;
  logic [7:0]  got_q[$];
  int          done_rises[$];
  logic [31:0] done_hdr[$];
  int          bp_mode = 0;
  logic [7:0]  ovr[int];
  logic [7:0]  seed;

  spi_flash_reader #(
    .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CS_HIGH_CYC(CS_HIGH_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .flash_sclk (flash_sclk),
    .flash_cs_n (flash_cs_n),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_T / 2) clk = ~clk;
  end

  // Flash array contents: explicit overrides, otherwise a hash of the address.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [31:0] h;
    if (ovr.exists(int'({8'h00, a}))) return ovr[int'({8'h00, a})];
    h = {8'h00, a} * 32'h9E37_79B1;
    return h[20:13] ^ seed;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Flash-side monitor: chip-select framing, header capture, rise counting.
  initial begin
    logic prev_cs;
    prev_cs = 1'b1;
    forever begin
      @(posedge flash_sclk or flash_cs_n);
      if (flash_cs_n !== prev_cs) begin
        if (flash_cs_n === 1'b0) begin
          cs_falls++;
          if (t_cs_rise != 0) cs_gap = $time - t_cs_rise;
          rise_cnt = 0;
          hdr      = '0;
        end else if (flash_cs_n === 1'b1) begin
          t_cs_rise = $time;
          done_rises.push_back(rise_cnt);
          done_hdr.push_back(hdr);
        end
        prev_cs = flash_cs_n;
      end else if (flash_sclk === 1'b1 && flash_cs_n === 1'b0) begin
        if (rise_cnt < 32) hdr = {hdr[30:0], flash_mosi};
        else if (flash_mosi !== 1'b0) mosi_bad++;
        rise_cnt++;
        if (rise_cnt == 1) t_r1 = $time;
        if (rise_cnt == 2) t_r2 = $time;
      end
    end
  end

  // Flash data output: after the header, shift bytes out MSB first on falling SCLK.
  initial begin
    int         idx;
    logic [7:0] b;
    flash_miso = 1'b0;
    forever begin
      @(negedge flash_sclk);
      if (flash_cs_n === 1'b0 && rise_cnt >= HDR) begin
        idx        = rise_cnt - HDR;
        b          = fbyte(24'(hdr[23:0] + 24'(idx / 8)));
        flash_miso = b[7 - (idx % 8)];
      end else begin
        flash_miso = 1'b0;
      end
    end
  end

  // Consumer: always ready, random ready, or one 40-cycle stall on the first byte.
  initial begin
    int stall_left, stall_rises;
    bit stall_done;
    stall_left  = 0;
    stall_rises = 0;
    stall_done  = 1'b0;
    rd_ready    = 1'b0;
    forever begin
      @(negedge clk);
      if (bp_mode != 2) stall_done = 1'b0;
      case (bp_mode)
        1: rd_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (stall_left > 0) begin
            rd_ready = 1'b0;
            stall_left--;
            if (stall_left == 0) begin
              checkOutput("bp_sclk_frozen", 32'(rise_cnt - stall_rises), 0);
              checkOutput("bp_sclk_low", {31'd0, flash_sclk}, 0);
              checkOutput("bp_cs_held", {31'd0, flash_cs_n}, 0);
            end
          end else if (!stall_done && rd_valid) begin
            stall_done  = 1'b1;
            stall_left  = 40;
            stall_rises = rise_cnt;
            rd_ready    = 1'b0;
          end else begin
            rd_ready = 1'b1;
          end
        end
        default: rd_ready = 1'b1;
      endcase
      if (rd_valid && rd_ready) got_q.push_back(rd_data);
    end
  end

  task automatic applyStimulus(input logic [23:0] addr, input int len, input int mode, input bit poke);
    int n, g0, d0, m0, f0, budget, cyc;
    bit poked;
    n      = len + 1;
    g0     = got_q.size();
    d0     = done_rises.size();
    m0     = mosi_bad;
    f0     = cs_falls;
    bp_mode = mode;
    budget = (HDR + 8 * n) * 2 * CLK_DIV * 4 + 400;
    cyc    = 0;
    while (!req_ready && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    req_addr  = addr;
    req_len   = LEN_W'(len);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("accept_cs_low", {31'd0, flash_cs_n}, 0);
    checkOutput("accept_busy", {31'd0, busy}, 1);
    checkOutput("accept_mosi", {31'd0, flash_mosi}, {31'd0, CMD_EXP[7]});
    poked = 1'b0;
    cyc   = 0;
    while (cyc < budget && !((got_q.size() - g0) >= n && !busy && done_rises.size() > d0)) begin
      @(negedge clk);
      cyc++;
      if (poke && !poked && (got_q.size() - g0) >= 1 && busy) begin
        checkOutput("busy_ready_low", {31'd0, req_ready}, 0);
        req_addr  = 24'hFFFFFF;
        req_valid = 1'b1;
        poked     = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
    end
    checkOutput("burst_done", {31'd0, cyc < budget}, 1);
    if (done_rises.size() > d0) begin
      checkOutput("sclk_rises", 32'(done_rises[d0]), 32'(HDR + 8 * n));
      checkOutput("mosi_header", done_hdr[d0], {CMD_EXP, addr});
    end
    checkOutput("mosi_quiet", 32'(mosi_bad - m0), 0);
    checkOutput("byte_count", 32'(got_q.size() - g0), 32'(n));
    for (int k = 0; k < n; k++)
      if (g0 + k < got_q.size())
        checkOutput($sformatf("byte%0d", k), {24'd0, got_q[g0 + k]}, {24'd0, fbyte(24'(addr + 24'(k)))});
    repeat (CS_HIGH_CYC + 4) @(negedge clk);
    checkOutput("single_cs_frame", 32'(cs_falls - f0), 1);
    checkOutput("idle_after", {31'd0, busy}, 0);
  endtask

  initial begin
    #(CLK_T * 90000);
    $display("[TB] FAIL watchdog: time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, g0, f0, cyc;
    seed      = 8'($urandom);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_cs_n", {31'd0, flash_cs_n}, 1);
    checkOutput("rst_sclk", {31'd0, flash_sclk}, 0);
    checkOutput("rst_mosi", {31'd0, flash_mosi}, 0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 0);
    checkOutput("rst_rd_data", {24'd0, rd_data}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 1);

    $display("[TB] basic read");
    ovr[int'(32'h012345)] = 8'hA5;
    ovr[int'(32'h012346)] = 8'h5A;
    ovr[int'(32'h012347)] = 8'hFF;
    ovr[int'(32'h012348)] = 8'h00;
    applyStimulus(24'h012345, 3, 0, 1'b0);
    checkOutput("sclk_period", 32'(t_r2 - t_r1), 32'(2 * CLK_DIV * CLK_T));

    $display("[TB] backpressure");
    applyStimulus(24'h012345, 3, 2, 1'b0);

    $display("[TB] back-to-back single bytes");
    d0 = done_rises.size();
    g0 = got_q.size();
    f0 = cs_falls;
    bp_mode   = 0;
    req_addr  = 24'h00A0C0;
    req_len   = '0;
    req_valid = 1'b1;
    cyc = 0;
    while (cyc < 2000 && !((done_rises.size() - d0) >= 2 && (got_q.size() - g0) >= 2 && !busy)) begin
      @(negedge clk);
      cyc++;
      if (cs_falls - f0 >= 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checkOutput("b2b_done", {31'd0, cyc < 2000}, 1);
    checkOutput("b2b_frames", 32'(cs_falls - f0), 2);
    checkOutput("b2b_cs_gap_ok", {31'd0, cs_gap >= time'(CS_HIGH_CYC * CLK_T)}, 1);
    for (int k = 0; k < 2; k++) begin
      if (d0 + k < done_rises.size())
        checkOutput($sformatf("b2b_rises%0d", k), 32'(done_rises[d0 + k]), 32'(HDR + 8));
      if (g0 + k < got_q.size())
        checkOutput($sformatf("b2b_byte%0d", k), {24'd0, got_q[g0 + k]}, {24'd0, fbyte(24'h00A0C0)});
    end

    $display("[TB] request while busy");
    applyStimulus(24'h3C5A96, 3, 0, 1'b1);

    $display("[TB] reset mid-address");
    g0 = got_q.size();
    req_addr  = 24'hABCDEF;
    req_len   = 8'd2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (rise_cnt < 12 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rst_mid_rises", 32'(rise_cnt), 12);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_cs_n", {31'd0, flash_cs_n}, 1);
    checkOutput("rst_mid_sclk", {31'd0, flash_sclk}, 0);
    checkOutput("rst_mid_rd_valid", {31'd0, rd_valid}, 0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_no_byte", 32'(got_q.size() - g0), 0);
    applyStimulus(24'h13579B, 2, 0, 1'b0);

    $display("[TB] address wrap and maximum length");
    applyStimulus(24'hFFFFFE, 3, 1, 1'b0);
    applyStimulus(24'h200000, 255, 0, 1'b0);
    applyStimulus(24'h000100, 0, 1, 1'b0);

    $display("[TB] random bursts");
    for (int i = 0; i < 6; i++)
      applyStimulus(24'($urandom), int'($urandom_range(0, 7)), 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
